// File: rtl/alu_pkg.sv
// Op-code encoding and helpers shared by the ALU and the ALU sharing arbiter.
// Build option ALU_SHARE_ARB_RR_EN (round-robin ties) is consumed by alu_share_arb_grant2.
package alu_pkg;

    localparam int unsigned ALU_OP_W    = 4;
    localparam int unsigned ALU_SHAMT_W = 5;
    localparam int unsigned ALU_DATA_W  = 32;

    typedef logic [ALU_OP_W-1:0] alu_op_t;

    localparam alu_op_t ALU_ADD  = 4'd0;
    localparam alu_op_t ALU_SUB  = 4'd1;
    localparam alu_op_t ALU_SLL  = 4'd2;
    localparam alu_op_t ALU_SLT  = 4'd3;
    localparam alu_op_t ALU_SLTU = 4'd4;
    localparam alu_op_t ALU_XOR  = 4'd5;
    localparam alu_op_t ALU_SRL  = 4'd6;
    localparam alu_op_t ALU_SRA  = 4'd7;
    localparam alu_op_t ALU_OR   = 4'd8;
    localparam alu_op_t ALU_AND  = 4'd9;

    // Shift ops only consume the low ALU_SHAMT_W bits of the second operand.
    function automatic logic is_shift(input alu_op_t op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

    // Compare ops produce a single-bit result zero-extended to the data width.
    function automatic logic is_compare(input alu_op_t op);
        return (op == ALU_SLT) || (op == ALU_SLTU);
    endfunction

endpackage

// File: rtl/alu.sv
// Team combinational 32-bit ALU; undefined op codes return zero.
module alu
    import alu_pkg::*;
(
    input  alu_op_t                 op,
    input  logic [ALU_DATA_W-1:0]   a,
    input  logic [ALU_DATA_W-1:0]   b,
    output logic [ALU_DATA_W-1:0]   result_c
);

    logic [ALU_SHAMT_W-1:0] shamt;
    logic                   lt_signed;
    logic                   lt_unsigned;

    assign shamt       = b[ALU_SHAMT_W-1:0];
    assign lt_signed   = $signed(a) < $signed(b);
    assign lt_unsigned = a < b;

    always_comb begin
        result_c = '0;
        case (op)
            ALU_ADD:  result_c = a + b;
            ALU_SUB:  result_c = a - b;
            ALU_SLL:  result_c = a << shamt;
            ALU_SLT:  result_c = ALU_DATA_W'(lt_signed);
            ALU_SLTU: result_c = ALU_DATA_W'(lt_unsigned);
            ALU_XOR:  result_c = a ^ b;
            ALU_SRL:  result_c = a >> shamt;
            ALU_SRA:  result_c = ALU_DATA_W'($signed(a) >>> shamt);
            ALU_OR:   result_c = a | b;
            ALU_AND:  result_c = a & b;
            default:  result_c = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arb_grant2.sv
// Two-way grant: one-hot grant from eligibility. With ALU_SHARE_ARB_RR_EN defined,
// ties alternate via a last-granted pointer; otherwise port 0 always wins ties.
module alu_share_arb_grant2 (
`ifdef ALU_SHARE_ARB_RR_EN
    input  logic       clk,
    input  logic       rst,
`endif
    input  logic [1:0] elig,
    output logic [1:0] grant_c
);

`ifdef ALU_SHARE_ARB_RR_EN
    // last_port = 1 means port 1 was granted most recently, so port 0 wins the next tie.
    logic last_port;

    always_comb begin
        grant_c = elig;
        if (elig == 2'b11) begin
            grant_c = last_port ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_port <= 1'b1;
        end else if (grant_c != 2'b00) begin
            last_port <= grant_c[1];
        end
    end
`else
    always_comb begin
        grant_c = elig;
        if (elig == 2'b11) begin
            grant_c = 2'b01;
        end
    end
`endif

endmodule

// File: rtl/alu_share_arb.sv
// Time-shares one combinational ALU between two valid/ready requesters with a
// one-entry response slot per port. ALU_SHARE_ARB_RR_EN selects round-robin ties.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int unsigned TAG_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [ALU_OP_W-1:0]     req0_op,
    input  logic [ALU_DATA_W-1:0]   req0_x,
    input  logic [ALU_DATA_W-1:0]   req0_y,
    input  logic [TAG_W-1:0]        req0_tag,

    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [ALU_OP_W-1:0]     req1_op,
    input  logic [ALU_DATA_W-1:0]   req1_x,
    input  logic [ALU_DATA_W-1:0]   req1_y,
    input  logic [TAG_W-1:0]        req1_tag,

    output logic                    rsp0_valid,
    input  logic                    rsp0_ready,
    output logic [ALU_DATA_W-1:0]   rsp0_data,
    output logic [TAG_W-1:0]        rsp0_tag,

    output logic                    rsp1_valid,
    input  logic                    rsp1_ready,
    output logic [ALU_DATA_W-1:0]   rsp1_data,
    output logic [TAG_W-1:0]        rsp1_tag
);

    logic [1:0]            elig;
    logic [1:0]            grant;
    logic [1:0]            rsp_rdy;
    logic [1:0]            slot_v;
    logic [ALU_DATA_W-1:0] slot_d [2];
    logic [TAG_W-1:0]      slot_t [2];

    alu_op_t               sel_op;
    logic [ALU_DATA_W-1:0] sel_x;
    logic [ALU_DATA_W-1:0] sel_y;
    logic [TAG_W-1:0]      sel_tag;
    logic [ALU_DATA_W-1:0] alu_y;
    logic [ALU_DATA_W-1:0] alu_res;

    assign rsp_rdy = {rsp1_ready, rsp0_ready};

    // A port may issue when its slot is empty or is being drained this cycle.
    assign elig[0] = !rst && req0_valid && (!slot_v[0] || rsp_rdy[0]);
    assign elig[1] = !rst && req1_valid && (!slot_v[1] || rsp_rdy[1]);

    alu_share_arb_grant2 u_grant (
`ifdef ALU_SHARE_ARB_RR_EN
        .clk     (clk),
        .rst     (rst),
`endif
        .elig    (elig),
        .grant_c (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // Operand steering into the shared ALU; port 0 is the idle default.
    always_comb begin
        sel_op  = alu_op_t'(req0_op);
        sel_x   = req0_x;
        sel_y   = req0_y;
        sel_tag = req0_tag;
        if (grant[1]) begin
            sel_op  = alu_op_t'(req1_op);
            sel_x   = req1_x;
            sel_y   = req1_y;
            sel_tag = req1_tag;
        end
    end

    assign alu_y = is_shift(sel_op) ? ALU_DATA_W'(sel_y[ALU_SHAMT_W-1:0]) : sel_y;

    alu u_alu (
        .op       (sel_op),
        .a        (sel_x),
        .b        (alu_y),
        .result_c (alu_res)
    );

    // Response slots: a refill wins over a same-cycle drain so valid stays high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_v <= 2'b00;
            for (int n = 0; n < 2; n++) begin
                slot_d[n] <= '0;
                slot_t[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (grant[n]) begin
                    slot_v[n] <= 1'b1;
                    slot_d[n] <= alu_res;
                    slot_t[n] <= sel_tag;
                end else if (slot_v[n] && rsp_rdy[n]) begin
                    slot_v[n] <= 1'b0;
                end
            end
        end
    end

    assign rsp0_valid = slot_v[0];
    assign rsp0_data  = slot_d[0];
    assign rsp0_tag   = slot_t[0];
    assign rsp1_valid = slot_v[1];
    assign rsp1_data  = slot_d[1];
    assign rsp1_tag   = slot_t[1];

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed vectors plus a per-cycle reference model.
module tb_alu_share_arb;

    localparam int unsigned TAG_W = 4;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [3:0]       req0_op = '0, req1_op = '0;
    logic [31:0]      req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
    logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
    logic             rsp0_valid, rsp1_valid;
    logic             rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [31:0]      rsp0_data, rsp1_data;
    logic [TAG_W-1:0] rsp0_tag, rsp1_tag;

    int checks = 0;
    int errors = 0;

    alu_share_arb #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .req1_tag   (req1_tag),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .rsp0_tag   (rsp0_tag),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .rsp1_tag   (rsp1_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: slot contents per port and, for round-robin, the last winner.
    logic             m_v [2] = '{1'b0, 1'b0};
    logic [31:0]      m_d [2] = '{32'd0, 32'd0};
    logic [TAG_W-1:0] m_t [2] = '{'0, '0};
`ifdef ALU_SHARE_ARB_RR_EN
    logic             m_last = 1'b1;
`endif

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] x,
                                            input logic [31:0] y);
        logic signed [31:0] sx;
        logic signed [31:0] sy;
        logic [4:0]         sh;
        sx = x;
        sy = y;
        sh = y[4:0];
        case (op)
            4'd0:    return x + y;
            4'd1:    return x - y;
            4'd2:    return x << sh;
            4'd3:    return (sx < sy) ? 32'd1 : 32'd0;
            4'd4:    return (x < y) ? 32'd1 : 32'd0;
            4'd5:    return x ^ y;
            4'd6:    return x >> sh;
            4'd7:    return 32'(sx >>> sh);
            4'd8:    return x | y;
            4'd9:    return x & y;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [1:0] exp_grant();
        logic e0, e1;
        e0 = !rst && req0_valid && (!m_v[0] || rsp0_ready);
        e1 = !rst && req1_valid && (!m_v[1] || rsp1_ready);
        if (e0 && e1) begin
`ifdef ALU_SHARE_ARB_RR_EN
            return m_last ? 2'b01 : 2'b10;
`else
            return 2'b01;
`endif
        end
        return {e1, e0};
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [1:0] g;
        if (rst) begin
            m_v[0] = 1'b0;
            m_v[1] = 1'b0;
            m_d[0] = '0;
            m_d[1] = '0;
            m_t[0] = '0;
            m_t[1] = '0;
`ifdef ALU_SHARE_ARB_RR_EN
            m_last = 1'b1;
`endif
        end else begin
            g = exp_grant();
            if (g[0]) begin
                m_v[0] = 1'b1;
                m_d[0] = ref_alu(req0_op, req0_x, req0_y);
                m_t[0] = req0_tag;
            end else if (m_v[0] && rsp0_ready) begin
                m_v[0] = 1'b0;
            end
            if (g[1]) begin
                m_v[1] = 1'b1;
                m_d[1] = ref_alu(req1_op, req1_x, req1_y);
                m_t[1] = req1_tag;
            end else if (m_v[1] && rsp1_ready) begin
                m_v[1] = 1'b0;
            end
`ifdef ALU_SHARE_ARB_RR_EN
            if (g != 2'b00) m_last = g[1];
`endif
        end
    end

    // Per-cycle compare on the falling edge, away from input changes and the active edge.
    always @(negedge clk) begin
        logic [1:0] g;
        g = exp_grant();
        chk("req0_ready", 32'(req0_ready), 32'(g[0]));
        chk("req1_ready", 32'(req1_ready), 32'(g[1]));
        chk("rsp0_valid", 32'(rsp0_valid), 32'(m_v[0]));
        chk("rsp1_valid", 32'(rsp1_valid), 32'(m_v[1]));
        if (m_v[0]) begin
            chk("rsp0_data", rsp0_data, m_d[0]);
            chk("rsp0_tag", 32'(rsp0_tag), 32'(m_t[0]));
        end
        if (m_v[1]) begin
            chk("rsp1_data", rsp1_data, m_d[1]);
            chk("rsp1_tag", 32'(rsp1_tag), 32'(m_t[1]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [TAG_W-1:0] tag);
        req0_valid = 1'b1;
        req0_op    = op;
        req0_x     = x;
        req0_y     = y;
        req0_tag   = tag;
    endtask

    task automatic set1(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [TAG_W-1:0] tag);
        req1_valid = 1'b1;
        req1_op    = op;
        req1_x     = x;
        req1_y     = y;
        req1_tag   = tag;
    endtask

    logic [3:0]  s_op [8] = '{OP_SUB, OP_ADD, OP_SLL, OP_XOR, OP_SRL, OP_OR, OP_AND, OP_SRA};
    logic [31:0] s_x  [8] = '{32'd5, 32'h10, 32'h1, 32'hAAAA5555, 32'h80000000,
                              32'h00F0, 32'hFFFF0000, 32'h7FFFFFFF};
    logic [31:0] s_y  [8] = '{32'd7, 32'h20, 32'd31, 32'hFFFF0000, 32'h21,
                              32'h0F00, 32'h0FF00FF0, 32'd3};

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("reset_rsp1_valid", 32'(rsp1_valid), 32'd0);
        chk("reset_rsp0_data", rsp0_data, 32'd0);
        chk("reset_rsp1_data", rsp1_data, 32'd0);
        chk("reset_rsp0_tag", 32'(rsp0_tag), 32'd0);
        chk("reset_rsp1_tag", 32'(rsp1_tag), 32'd0);

        // Single ADD on port 0
        set0(OP_ADD, 32'h7FFFFFFF, 32'd1, 4'd3);
        #1 chk("single_ready", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 1'b0;
        chk("single_valid", 32'(rsp0_valid), 32'd1);
        chk("single_data", rsp0_data, 32'h80000000);
        chk("single_tag", 32'(rsp0_tag), 32'd3);

        // Port 1 op so port 1 is the last winner before contention
        set1(OP_XOR, 32'h0000F0F0, 32'h00000FF0, 4'd1);
        step();
        req1_valid = 1'b0;
        chk("xor_data", rsp1_data, 32'h0000FF00);
        step();

        // Contention: both valid for six cycles
        for (int i = 0; i < 6; i++) begin
            set0(OP_ADD, 32'(i), 32'd100, 4'(i));
            set1(OP_SUB, 32'd100, 32'(i), 4'(i + 8));
            #1;
`ifdef ALU_SHARE_ARB_RR_EN
            chk("cont_grant0", 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("cont_grant1", 32'(req1_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
`else
            chk("cont_grant0", 32'(req0_ready), 32'd1);
            chk("cont_grant1", 32'(req1_ready), 32'd0);
`endif
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();

        // Back-pressure on port 1 while port 0 keeps flowing
        rsp1_ready = 1'b0;
        set1(OP_OR, 32'h0000000F, 32'h000000F0, 4'd5);
        step();
        chk("bp_hold_data", rsp1_data, 32'h000000FF);
        set1(OP_SRA, 32'h80000000, 32'h00000024, 4'd6);
        set0(OP_AND, 32'hFF00FF00, 32'h0FF00FF0, 4'd2);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready1_stalled", 32'(req1_ready), 32'd0);
            chk("bp_ready0_indep", 32'(req0_ready), 32'd1);
            step();
        end
        req0_valid = 1'b0;
        chk("bp_port0_data", rsp0_data, 32'h0F000F00);
        chk("bp_port1_held", rsp1_data, 32'h000000FF);
        rsp1_ready = 1'b1;
        #1 chk("bp_drain_ready", 32'(req1_ready), 32'd1);
        step();
        req1_valid = 1'b0;
        chk("bp_sra_data", rsp1_data, 32'hF8000000);
        chk("bp_sra_tag", 32'(rsp1_tag), 32'd6);
        step();

        // Eight back-to-back ops on port 0 with same-cycle drain and refill
        for (int i = 0; i < 8; i++) begin
            set0(s_op[i], s_x[i], s_y[i], 4'(i));
            step();
            chk("stream_valid", 32'(rsp0_valid), 32'd1);
            if (i == 0) chk("stream_first_data", rsp0_data, 32'hFFFFFFFE);
        end
        req0_valid = 1'b0;
        step();

        // Compare and undefined ops
        set0(OP_SLT, 32'hFFFFFFFF, 32'd1, 4'd7);
        step();
        chk("slt_data", rsp0_data, 32'd1);
        set0(OP_SLTU, 32'hFFFFFFFF, 32'd1, 4'd8);
        step();
        chk("sltu_data", rsp0_data, 32'd0);
        set0(4'd12, 32'h1234, 32'h5678, 4'd9);
        step();
        chk("undef_data", rsp0_data, 32'd0);
        chk("undef_tag", 32'(rsp0_tag), 32'd9);
        chk("undef_valid", 32'(rsp0_valid), 32'd1);
        req0_valid = 1'b0;
        step();

        // Reset with both slots full
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        set0(OP_ADD, 32'd1, 32'd2, 4'd1);
        set1(OP_ADD, 32'd3, 32'd4, 4'd2);
        step();
        step();
        chk("full_rsp0_valid", 32'(rsp0_valid), 32'd1);
        chk("full_rsp1_valid", 32'(rsp1_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        chk("rst_req0_ready", 32'(req0_ready), 32'd0);
        chk("rst_req1_ready", 32'(req1_ready), 32'd0);
        step();
        rst = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        #1;
        chk("post_rst_tie0", 32'(req0_ready), 32'd1);
        chk("post_rst_tie1", 32'(req1_ready), 32'd0);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("post_rst_data", rsp0_data, 32'd3);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
